// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings
// and FSM state type, used by both the control FSM and the datapath decode.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // True for the op class that runs the restoring divider.
  function automatic logic isDivOp(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / divide unit. One result bit per cycle:
// shift-add multiply and restoring divide share a single shift register
// pair (accReg/lowReg) and a single WIDTH+1-bit adder.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  import muldiv_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, nextState;
  logic [CNT_W-1:0] count;
  logic [1:0]       opReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH:0]   accReg;     // product upper half / remainder
  logic [WIDTH-1:0] lowReg;     // product lower half / quotient
  logic [WIDTH-1:0] resultReg;

  logic             accept;
  logic             divByZero;
  logic             lastIter;
  logic             divClass;
  logic [WIDTH:0]   shiftedRem;
  logic [WIDTH:0]   addA;
  logic [WIDTH:0]   addB;
  logic             carryIn;
  logic [WIDTH+1:0] addSum;
  logic             remGe;
  logic [WIDTH:0]   accNext;
  logic [WIDTH-1:0] lowNext;

  // Picks the published half of the shift register for the latched op.
  function automatic logic [WIDTH-1:0] selectResult(input logic [1:0] selOp,
                                                    input logic [WIDTH:0] acc,
                                                    input logic [WIDTH-1:0] low);
    case (selOp)
      OP_MULHU, OP_REMU: return acc[WIDTH-1:0];
      default:           return low;
    endcase
  endfunction

  assign accept     = start && (state != S_RUN);
  assign divByZero  = accept && isDivOp(op) && (operandB == '0);
  assign lastIter   = (state == S_RUN) && (count == CNT_W'(WIDTH - 1));
  assign divClass   = isDivOp(opReg);
  assign shiftedRem = {accReg[WIDTH-1:0], lowReg[WIDTH-1]};
  assign addSum     = {1'b0, addA} + {1'b0, addB} + {{(WIDTH+1){1'b0}}, carryIn};
  assign remGe      = addSum[WIDTH+1];
  assign result     = resultReg;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= nextState;
  end

  // Next-state decode and status outputs (decoded from the state flops only).
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) nextState = divByZero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (lastIter) nextState = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) nextState = divByZero ? S_DONE : S_RUN;
        else       nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  // Shared adder operands: add multiplicand for multiply, trial-subtract divisor for divide.
  always_comb begin
    addA    = '0;
    addB    = '0;
    carryIn = 1'b0;
    accNext = accReg;
    lowNext = lowReg;
    if (divClass) begin
      addA    = shiftedRem;
      addB    = ~{1'b0, bReg};
      carryIn = 1'b1;
      accNext = remGe ? addSum[WIDTH:0] : shiftedRem;
      lowNext = {lowReg[WIDTH-2:0], remGe};
    end else begin
      addA    = accReg;
      addB    = lowReg[0] ? {1'b0, bReg} : '0;
      accNext = {1'b0, addSum[WIDTH:1]};
      lowNext = {addSum[0], lowReg[WIDTH-1:1]};
    end
  end

  // Operand latch, iteration step, and result publish on entry to DONE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count     <= '0;
      opReg     <= OP_MUL;
      bReg      <= '0;
      accReg    <= '0;
      lowReg    <= '0;
      resultReg <= '0;
    end else if (accept) begin
      count  <= '0;
      opReg  <= op;
      bReg   <= operandB;
      accReg <= '0;
      lowReg <= operandA;
      if (divByZero) resultReg <= (op == OP_DIVU) ? '1 : operandA;
    end else if (state == S_RUN) begin
      count  <= count + 1'b1;
      accReg <= accNext;
      lowReg <= lowNext;
      if (lastIter) resultReg <= selectResult(opReg, accNext, lowNext);
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: WIDTH=32 and WIDTH=8 instances.
module tb_muldiv_unit;

  logic        clock;
  logic        reset32, start32, busy32, done32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, result32;
  logic        reset8, start8, busy8, done8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, result8;

  int checkCount = 0;
  int errorCount = 0;
  int doneCnt32  = 0;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset32), .start(start32), .op(op32),
    .operandA(a32), .operandB(b32), .busy(busy32), .done(done32), .result(result32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset8), .start(start8), .op(op8),
    .operandA(a8), .operandB(b8), .busy(busy8), .done(done8), .result(result8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (done32 === 1'b1) doneCnt32++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errorCount);
    $fatal(1, "watchdog");
  end

  task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 8) begin
      start8 = s; op8 = o; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = s; op32 = o; a32 = a; b32 = b;
    end
  endtask

  function automatic logic curDone(input int w);
    return (w == 8) ? done8 : done32;
  endfunction

  function automatic logic curBusy(input int w);
    return (w == 8) ? busy8 : busy32;
  endfunction

  function automatic logic [31:0] curResult(input int w);
    return (w == 8) ? {24'b0, result8} : result32;
  endfunction

  // Called #1 after an edge; counts edges until done is seen.
  task automatic waitDone(input int w, output int lat, output int busyCycles,
                          output logic [31:0] res);
    lat = 0;
    busyCycles = 0;
    while (curDone(w) !== 1'b1 && lat < 200) begin
      if (curBusy(w) === 1'b1) busyCycles++;
      @(posedge clock); #1;
      lat++;
    end
    if (curDone(w) !== 1'b1) checkValue("done timeout", {31'b0, curDone(w)}, 32'd1);
    res = curResult(w);
  endtask

  task automatic runOp(input int w, input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input int expLat);
    int lat, busyCycles;
    logic [31:0] res;
    @(negedge clock);
    drive(w, 1'b1, o, a, b);
    @(posedge clock); #1;
    drive(w, 1'b0, o, a, b);
    waitDone(w, lat, busyCycles, res);
    checkValue({tag, " result"}, res, expRes);
    checkValue({tag, " latency"}, 32'(lat), 32'(expLat));
    checkValue({tag, " busy cycles"}, 32'(busyCycles), 32'(expLat));
    @(posedge clock); #1;
  endtask

  initial begin
    int lat, busyCycles, doneBefore;
    logic [31:0] res;

    reset32 = 1'b0; reset8 = 1'b0;
    drive(32, 1'b0, 2'b00, 32'd0, 32'd0);
    drive(8, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    checkValue("reset busy32", {31'b0, busy32}, 32'd0);
    checkValue("reset done32", {31'b0, done32}, 32'd0);
    checkValue("reset result32", result32, 32'd0);
    checkValue("reset busy8", {31'b0, busy8}, 32'd0);
    checkValue("reset done8", {31'b0, done8}, 32'd0);
    checkValue("reset result8", {24'b0, result8}, 32'd0);
    @(negedge clock);
    reset32 = 1'b1; reset8 = 1'b1;
    @(posedge clock); #1;

    // WIDTH=32 arithmetic
    runOp(32, "mul 7x6", 2'b00, 32'd7, 32'd6, 32'd42, 32);
    runOp(32, "mul ffff^2", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32);
    runOp(32, "mulhu ffff^2", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
    runOp(32, "mulhu 8000x2", 2'b01, 32'h80000000, 32'd2, 32'h00000001, 32);
    runOp(32, "divu 100/7", 2'b10, 32'd100, 32'd7, 32'd14, 32);
    runOp(32, "remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32);
    runOp(32, "divu 7/100", 2'b10, 32'd7, 32'd100, 32'd0, 32);
    runOp(32, "remu 7/100", 2'b11, 32'd7, 32'd100, 32'd7, 32);
    runOp(32, "divu 5/0", 2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
    runOp(32, "remu 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 0);

    // start pulsed mid-RUN with new operands is ignored
    @(negedge clock);
    drive(32, 1'b1, 2'b00, 32'd7, 32'd6);
    @(posedge clock); #1;
    drive(32, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    drive(32, 1'b1, 2'b10, 32'd100, 32'd7);
    @(posedge clock); #1;
    drive(32, 1'b0, 2'b10, 32'd100, 32'd7);
    checkValue("midrun busy", {31'b0, busy32}, 32'd1);
    waitDone(32, lat, busyCycles, res);
    checkValue("midrun result", res, 32'd42);
    checkValue("midrun latency", 32'(lat), 32'd26);
    @(posedge clock); #1;

    // start held through DONE chains a second op with no gap
    doneBefore = doneCnt32;
    @(negedge clock);
    drive(32, 1'b1, 2'b00, 32'd3, 32'd5);
    @(posedge clock); #1;
    drive(32, 1'b1, 2'b10, 32'd100, 32'd7);
    waitDone(32, lat, busyCycles, res);
    checkValue("chain first result", res, 32'd15);
    checkValue("chain first latency", 32'(lat), 32'd32);
    @(posedge clock); #1;
    drive(32, 1'b0, 2'b10, 32'd0, 32'd0);
    checkValue("chain done dropped", {31'b0, done32}, 32'd0);
    checkValue("chain busy again", {31'b0, busy32}, 32'd1);
    waitDone(32, lat, busyCycles, res);
    checkValue("chain second result", res, 32'd14);
    checkValue("chain second latency", 32'(lat), 32'd32);
    @(posedge clock); #1;
    checkValue("chain done pulses", 32'(doneCnt32 - doneBefore), 32'd2);

    // reset in RUN cycle 10 aborts without a done pulse
    @(negedge clock);
    drive(32, 1'b1, 2'b00, 32'd9, 32'd9);
    @(posedge clock); #1;
    drive(32, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (9) @(posedge clock);
    #1;
    checkValue("pre-abort busy", {31'b0, busy32}, 32'd1);
    doneBefore = doneCnt32;
    @(negedge clock);
    reset32 = 1'b0;
    @(posedge clock); #1;
    checkValue("abort busy", {31'b0, busy32}, 32'd0);
    checkValue("abort done", {31'b0, done32}, 32'd0);
    checkValue("abort result", result32, 32'd0);
    @(negedge clock);
    reset32 = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    checkValue("abort no done", 32'(doneCnt32 - doneBefore), 32'd0);

    // WIDTH=8 instance
    runOp(8, "w8 mul 15x17", 2'b00, 32'd15, 32'd17, 32'd255, 8);
    runOp(8, "w8 mulhu 255^2", 2'b01, 32'd255, 32'd255, 32'd254, 8);
    runOp(8, "w8 divu 200/3", 2'b10, 32'd200, 32'd3, 32'd66, 8);
    runOp(8, "w8 remu 200/3", 2'b11, 32'd200, 32'd3, 32'd2, 8);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit: a parametrised successor to the single-cycle ALU that adds unsigned multiply, multiply-high, divide and remainder. Operands are accepted with a start/busy/done handshake, and the result is computed one bit per cycle. It sits beside the ALU in the datapath; the control stalls the PC while `busy` is high and writes `result` back on `done`.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 4).
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only when `busy`=0.
- op  in  2  00 MUL (low half), 01 MULHU (high half, unsigned), 10 DIVU, 11 REMU.
- operandA  in  WIDTH  multiplicand / dividend.
- operandB  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation iterates.
- done  out  1  one-cycle pulse when `result` becomes valid.
- result  out  WIDTH  last completed result, held until the next completion.

## Operation
- FSM states:
  - IDLE.
  - RUN: iterating.
  - DONE: result publish, one cycle.
- Transitions:
  - IDLE/DONE → RUN on `start`=1, normal case.
  - IDLE/DONE → DONE on `start`=1 for DIVU/REMU with `operandB`=0.
  - RUN → DONE when the iteration counter reaches WIDTH−1.
  - DONE → IDLE when `start`=0.
- On accept, the unit latches `op`, `operandA` and `operandB`, and clears the counter ($clog2(WIDTH) bits).
- Multiply (shift-add):
  - Product register is 2·WIDTH bits, initialised {0, operandA}.
  - Each cycle: if product LSB=1, add operandB to the upper half (WIDTH+1-bit sum including carry), then shift right by 1.
  - MUL returns product[WIDTH−1:0]; MULHU returns product[2·WIDTH−1:WIDTH].
- Divide (restoring):
  - Remainder register is WIDTH+1 bits; quotient is shifted in from the LSB.
  - Each cycle: shift {rem, quot} left by 1, trial-subtract the divisor, keep the difference and set the quotient bit if it is non-negative.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: DIVU result = all ones, REMU result = operandA (RISC-V semantics), with no iteration.
- `start` while `busy`=1: ignored; operands are not re-latched.
- Inputs may change freely after the accept edge.
- `result` is updated only on entry to DONE; otherwise it holds its value.

## Timing
- Reset (reset=0 at an edge):
  - State = IDLE, counter = 0, busy = 0, done = 0, result = 0.
  - Internal product, remainder and quotient registers are cleared.
  - Reset in the middle of an operation aborts it with no `done` pulse; `busy` is 0 after that edge.
- Accept at edge k (busy=0, start=1):
  - `busy`=1 from after edge k through edge k+WIDTH.
  - DONE is entered at edge k+WIDTH; `done`=1 and `result` are valid in cycle k+WIDTH (until edge k+WIDTH+1).
  - Latency is therefore WIDTH cycles from the accept edge to the `done` cycle.
- Divide by zero: DONE at edge k; `done`=1 in the next cycle, with `busy` never asserted.
- Back-to-back: `start`=1 during the DONE cycle is accepted at the edge that ends it. No idle cycle is required, and `done` does not stay high into the new operation.
- `busy` and `done` are mutually exclusive and both registered (no combinational path from inputs).

## Structure
- The package `muldiv_pkg` holds:
  - op encodings OP_MUL, OP_MULHU, OP_DIVU, OP_REMU (2-bit localparams);
  - the state enum {S_IDLE, S_RUN, S_DONE}.
  - The datapath control decoder imports the same op encodings.
- Single module with no sub-modules: the shared shift register and adder/subtractor are smaller inline than split. The WIDTH+1-bit add/sub is one shared adder, muxed by op class.

## Test plan
- WIDTH=32, MUL 7×6:
  - result=42, `done` exactly 32 cycles after the accept edge;
  - `busy` high for 32 cycles.
- MUL and MULHU with 0xFFFFFFFF×0xFFFFFFFF → 0x00000001 and 0xFFFFFFFE respectively; MULHU 0x80000000×2 → 0x00000001.
- DIVU 100÷7 → 14 and REMU 100÷7 → 2; DIVU 7÷100 → 0 and REMU 7÷100 → 7.
- Divide by zero:
  - DIVU 5÷0 → 0xFFFFFFFF and REMU 5÷0 → 5;
  - `done` in the cycle after the accept edge, with `busy` never high.
- Handshake stress:
  - `start` pulsed with new operands mid-RUN is ignored and the original result is produced.
  - `start` held during the DONE cycle chains a second operation with no gap; `done` is seen once per operation.
  - Reset driven low in RUN cycle 10: no `done`, and busy=0 and result=0 after that edge.
- WIDTH=8 instance: MUL 15×17 → 255, MULHU 255×255 → 254, DIVU 200÷3 → 66, REMU 200÷3 → 2, each with 8-cycle latency.
